mano_program_memory: RTL
========================

// Module: mano_program_memory
// PURPOSE
//  Program/data store placed directly upstream of the Mano datapath's MBR fetch: a 9-byte
//  memory filled over a byte-wide valid/ready load port, then served to the CPU as a
//  registered read port addressed by MAR.
//  Owns the load-then-run sequencing. cpu_run holds the T-counter/CPU idle until a complete image is in place.
// PARAMETERS
//  DEPTH  9  number of 8-bit words (addresses 0..DEPTH-1)
//  AW     4  address width, must satisfy 2**AW >= DEPTH
//  DW     8  data width
// PORTS
//  SysClk    in   1   system clock, all state on rising edge
//  rst_n     in   1   reset, asynchronous, active-low
//  ld_req    in   1   start/restart a full image load (level sampled each cycle)
//  ld_valid  in   1   ld_data holds a valid program byte
//  ld_data   in   DW  program byte
//  ld_ready  out  1   loader accepts a byte this cycle
//  ld_count  out  AW  bytes accepted so far in current load
//  cpu_run   out  1   image complete, CPU may execute
//  rd_req    in   1   CPU read strobe (x4 micro-op)
//  rd_addr   in   AW  read address (MAR)
//  rd_data   out  DW  read data, registered
//  rd_valid  out  1   one-cycle pulse, rd_data valid
//  rd_err    out  1   one-cycle pulse, rd_addr >= DEPTH
// BEHAVIOUR
//  Reset: state=IDLE; ld_ready=0, ld_count=0, cpu_run=0, rd_data=0, rd_valid=0, rd_err=0.
//   All memory words cleared to 0.
//  FSM IDLE -> LOAD -> RUN:
//   IDLE: ld_req=1 -> LOAD with ld_count=0. All other inputs ignored.
//   LOAD: ld_ready=1. Each cycle with ld_valid&ld_ready: mem[ld_count]<=ld_data, ld_count++.
//    Accepting byte DEPTH-1 -> RUN next cycle; ld_count holds DEPTH.
//    ld_req=1 in LOAD -> ld_count<=0, no write that cycle (ld_req wins over ld_valid).
//    Prior words keep their old values until overwritten.
//   RUN: cpu_run=1, ld_ready=0. ld_req=1 -> LOAD, ld_count=0. cpu_run drops the next cycle.
//  ld_ready and cpu_run are decoded from registered state only, with no comb path from inputs.
//  Read port, active only in RUN. rd_req sampled at edge N -> at edge N+1:
//   - rd_addr<DEPTH: rd_data=mem[rd_addr], rd_valid=1.
//   - rd_addr>=DEPTH: rd_data=0, rd_valid=1, rd_err=1.
//   rd_data holds its value between reads. Back-to-back rd_req gives one result per cycle.
//   rd_req outside RUN: ignored, no pulses.
//   rd_req in the same cycle ld_req leaves RUN: the read completes (state is still RUN at that edge).
//  Memory is not writable by the CPU. A write and a read never target the array in the same cycle.
//  ld_count arithmetic is AW bits wide and never exceeds DEPTH (no wrap).
//  Async reset mid-load or mid-read: immediate return to reset values. A partial image is discarded.
// STRUCTURE
//  Shared package mano_pkg:
//   - state encoding typedef mano_ld_state_t {IDLE, LOAD, RUN}
//   - MANO_MEM_DEPTH=9 and MANO_DW=8, also used by the datapath.
//  Sub-module mano_mem_array: DEPTH x DW registers, sync write (we, waddr, wdata),
//   registered read with range check, async clear.
//  FSM and counter stay in the top module.
// TESTING
//  1 Reset, then rd_req in IDLE -> cpu_run=0, rd_valid never pulses, ld_ready=0.
//  2 ld_req, then stream bytes 0x10..0x18 with ld_valid held high
//    -> ld_count 0..9, cpu_run=1 exactly one cycle after the 9th accept.
//  3 In RUN read addr 0,4,8 back-to-back -> rd_data 0x10,0x14,0x18 on consecutive cycles, rd_valid=1 each.
//  4 Read addr 9 and 15 -> rd_data=0x00, rd_valid=1, rd_err=1. rd_err=0 on in-range reads.
//  5 After 5 bytes, assert ld_req with ld_valid=1 -> no write that cycle, ld_count=0.
//    Reload 0xA0..0xA8 -> mem reads 0xA0..0xA8.
//  6 Assert rst_n=0 mid-load (ld_count=3) -> all outputs reset at once.
//    Reads after a fresh load return only the new image.

Source files
------------

// File: rtl/mano_pkg.sv
// Shared Mano machine definitions: memory geometry and the program-loader state encoding.
// Imported by the program memory and by the datapath.
package mano_pkg;

  localparam int MANO_MEM_DEPTH = 9;
  localparam int MANO_DW        = 8;
  localparam int MANO_AW        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } mano_ld_state_t;

endpackage

// File: rtl/mano_program_memory_if.sv
// Byte-wide image load port plus the CPU's registered read port.
// The master side is the loader/CPU; the slave side is the program memory.
interface mano_program_memory_if
  import mano_pkg::*;
#(
  parameter int AW = MANO_AW,
  parameter int DW = MANO_DW
);

  logic          ld_req;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic [AW-1:0] ld_count;
  logic          cpu_run;

  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_err;

  modport master (
    output ld_req, ld_valid, ld_data, rd_req, rd_addr,
    input  ld_ready, ld_count, cpu_run, rd_data, rd_valid, rd_err
  );

  modport slave (
    input  ld_req, ld_valid, ld_data, rd_req, rd_addr,
    output ld_ready, ld_count, cpu_run, rd_data, rd_valid, rd_err
  );

endinterface

// File: rtl/mano_mem_array.sv
// DEPTH x DW register file: synchronous write, registered range-checked read, async clear.
// Out-of-range reads return zero with an error pulse instead of aliasing.
module mano_mem_array
  import mano_pkg::*;
#(
  parameter int DEPTH = MANO_MEM_DEPTH,
  parameter int AW    = MANO_AW,
  parameter int DW    = MANO_DW
) (
  input  logic          SysClk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o,
  output logic          rvalid_o,
  output logic          rerr_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdData_q;
  logic          rdValid_q;
  logic          rdErr_q;

  logic waddrOk;
  logic raddrOk;

  assign waddrOk = (int'(waddr_i) < DEPTH);
  assign raddrOk = (int'(raddr_i) < DEPTH);

  // rd_data only moves on an accepted read so the CPU can sample it late.
  always_ff @(posedge SysClk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
      rdErr_q   <= 1'b0;
    end else begin
      if (we_i && waddrOk) begin
        mem_q[waddr_i] <= wdata_i;
      end
      rdValid_q <= re_i;
      rdErr_q   <= re_i && !raddrOk;
      if (re_i) begin
        rdData_q <= raddrOk ? mem_q[raddr_i] : '0;
      end
    end
  end

  assign rdata_o  = rdData_q;
  assign rvalid_o = rdValid_q;
  assign rerr_o   = rdErr_q;

endmodule

// File: rtl/mano_program_memory.sv
// Program store ahead of the Mano MBR fetch: loads a full image over the byte port,
// then releases the CPU (cpu_run) and serves registered reads addressed by MAR.
module mano_program_memory
  import mano_pkg::*;
#(
  parameter int DEPTH = MANO_MEM_DEPTH,
  parameter int AW    = MANO_AW,
  parameter int DW    = MANO_DW
) (
  input  logic                   SysClk,
  input  logic                   rst_n,
  mano_program_memory_if.slave   bus
);

  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  mano_ld_state_t state_q, state_d;
  logic [AW-1:0]  ldCount_q, ldCount_d;
  logic           ldReady_q;
  logic           cpuRun_q;
  logic           memWe;
  logic           rdEn;

  // A restart request beats a byte offered in the same cycle, so nothing is written then.
  always_comb begin
    state_d   = state_q;
    ldCount_d = ldCount_q;
    memWe     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ld_req) begin
          state_d   = LOAD;
          ldCount_d = '0;
        end
      end
      LOAD: begin
        if (bus.ld_req) begin
          ldCount_d = '0;
        end else if (bus.ld_valid) begin
          memWe     = 1'b1;
          ldCount_d = ldCount_q + AW'(1);
          if (ldCount_q == LastIdx) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bus.ld_req) begin
          state_d   = LOAD;
          ldCount_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        ldCount_d = '0;
      end
    endcase
  end

  // ld_ready/cpu_run are registered from the next state so no input reaches them combinationally.
  always_ff @(posedge SysClk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ldCount_q <= '0;
      ldReady_q <= 1'b0;
      cpuRun_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ldCount_q <= ldCount_d;
      ldReady_q <= (state_d == LOAD);
      cpuRun_q  <= (state_d == RUN);
    end
  end

  // Reads are gated on the current state, so a read issued alongside a reload still completes.
  assign rdEn = (state_q == RUN) && bus.rd_req;

  mano_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_mem (
    .SysClk   (SysClk),
    .rst_n    (rst_n),
    .we_i     (memWe),
    .waddr_i  (ldCount_q),
    .wdata_i  (bus.ld_data),
    .re_i     (rdEn),
    .raddr_i  (bus.rd_addr),
    .rdata_o  (bus.rd_data),
    .rvalid_o (bus.rd_valid),
    .rerr_o   (bus.rd_err)
  );

  assign bus.ld_ready = ldReady_q;
  assign bus.ld_count = ldCount_q;
  assign bus.cpu_run  = cpuRun_q;

endmodule
